cache_refill_responder: RTL

- Memory-side responder for the direct-mapped cache. It answers line-fill reads with a burst of one cache block, critical word first, and absorbs single-word write-through stores.
- Sits between the cache miss path and the main-memory model.
- Used as the backing store in cache system simulation and as the template for the future real memory controller.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_mem_array.sv | 25 ++
 rtl/cache_refill_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache geometry and responder state encoding, so the cache and its
// backing-store responder agree on block layout.
package cache_pkg;

    localparam int BLOCK_SIZE        = 32;
    localparam int WORD_BYTES        = 4;
    localparam int WORDS_PER_BLOCK   = BLOCK_SIZE / WORD_BYTES;
    localparam int OFFSET_WIDTH      = $clog2(WORDS_PER_BLOCK);
    localparam int BYTE_OFFSET_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } rsp_state_e;

    // Number of 32-bit words in a block of the given byte size.
    function automatic int block_words(input int block_bytes);
        return block_bytes / WORD_BYTES;
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Single-port word RAM: synchronous write, combinational read, no reset
// (contents are undefined until written).
module cache_mem_array #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store the write word on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/cache_refill_responder.sv
// Memory-side responder: absorbs write-through stores and answers block
// fills with a critical-word-first wrapping burst after a fixed latency.
module cache_refill_responder
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BLOCK_SIZE   = cache_pkg::BLOCK_SIZE,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]             req_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic [$clog2(BLOCK_SIZE/4)-1:0]   rsp_word_idx,
    output logic                              rsp_last,
    output logic                              busy
);

    localparam int WPB   = block_words(BLOCK_SIZE);
    localparam int OFF_W = $clog2(WPB);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int HI_W  = IDX_W - OFF_W;
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WPB - 1);

    rsp_state_e            state_r, state_nxt_s;
    logic [CNT_W-1:0]      lat_cnt_r, lat_cnt_nxt_s;
    logic [OFF_W-1:0]      beat_cnt_r, beat_cnt_nxt_s;
    logic [HI_W-1:0]       base_hi_r, base_hi_nxt_s;
    logic [OFF_W-1:0]      off_r, off_nxt_s;
    logic [DATA_WIDTH-1:0] rsp_data_r, data_nxt_s;
    logic                  rsp_valid_r, valid_nxt_s;
    logic                  rsp_last_r, last_nxt_s;
    logic                  req_ready_r, ready_nxt_s;
    logic                  busy_r, busy_nxt_s;

    logic [IDX_W-1:0]      req_idx_s, mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_rdata_s;
    logic                  req_fire_s, rd_fire_s, wr_fire_s, beat_fire_s;
    logic                  unused_addr_s;

    // Word index ignores byte offset and high address bits (aliasing).
    assign req_idx_s     = req_addr[IDX_W+1:2];
    assign unused_addr_s = ^{req_addr[ADDR_WIDTH-1:IDX_W+2], req_addr[1:0]};

    assign req_fire_s  = req_valid & req_ready_r;
    assign rd_fire_s   = req_fire_s & ~req_write;
    assign wr_fire_s   = req_fire_s & req_write;
    assign beat_fire_s = rsp_valid_r & rsp_ready;

    // RAM address: request word in IDLE, current beat in WAIT, next beat in BURST.
    always_comb begin
        mem_addr_s = req_idx_s;
        case (state_r)
            IDLE:    mem_addr_s = req_idx_s;
            WAIT:    mem_addr_s = {base_hi_r, off_r};
            BURST:   mem_addr_s = {base_hi_r, off_r + OFF_W'(1)};
            default: mem_addr_s = req_idx_s;
        endcase
    end

    cache_mem_array #(
        .DEPTH (MEM_WORDS),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire_s),
        .addr  (mem_addr_s),
        .wdata (req_wdata),
        .rdata (mem_rdata_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rd_fire_s) begin
                    if (READ_LATENCY == 1) begin
                        state_nxt_s = BURST;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (lat_cnt_r == CNT_W'(1)) begin
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            BURST: begin
                if (beat_fire_s && rsp_last_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BURST;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of counters, burst pointer and registered outputs.
    always_comb begin
        lat_cnt_nxt_s  = lat_cnt_r;
        beat_cnt_nxt_s = beat_cnt_r;
        base_hi_nxt_s  = base_hi_r;
        off_nxt_s      = off_r;
        data_nxt_s     = rsp_data_r;
        valid_nxt_s    = rsp_valid_r;
        last_nxt_s     = rsp_last_r;
        ready_nxt_s    = req_ready_r;
        busy_nxt_s     = busy_r;
        case (state_r)
            IDLE: begin
                if (rd_fire_s) begin
                    base_hi_nxt_s  = req_idx_s[IDX_W-1:OFF_W];
                    off_nxt_s      = req_idx_s[OFF_W-1:0];
                    beat_cnt_nxt_s = '0;
                    ready_nxt_s    = 1'b0;
                    busy_nxt_s     = 1'b1;
                    if (READ_LATENCY == 1) begin
                        valid_nxt_s = 1'b1;
                        data_nxt_s  = mem_rdata_s;
                        last_nxt_s  = (LAST_BEAT == '0);
                    end else begin
                        lat_cnt_nxt_s = LAT_LOAD;
                    end
                end else begin
                    ready_nxt_s = 1'b1;
                end
            end
            WAIT: begin
                if (lat_cnt_r == CNT_W'(1)) begin
                    lat_cnt_nxt_s = '0;
                    valid_nxt_s   = 1'b1;
                    data_nxt_s    = mem_rdata_s;
                    last_nxt_s    = (LAST_BEAT == '0);
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r - CNT_W'(1);
                end
            end
            BURST: begin
                if (beat_fire_s) begin
                    if (rsp_last_r) begin
                        valid_nxt_s = 1'b0;
                        last_nxt_s  = 1'b0;
                        ready_nxt_s = 1'b1;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        off_nxt_s      = off_r + OFF_W'(1);
                        beat_cnt_nxt_s = beat_cnt_r + OFF_W'(1);
                        data_nxt_s     = mem_rdata_s;
                        last_nxt_s     = ((beat_cnt_r + OFF_W'(1)) == LAST_BEAT);
                    end
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                last_nxt_s  = 1'b0;
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any burst immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt_r   <= '0;
            beat_cnt_r  <= '0;
            base_hi_r   <= '0;
            off_r       <= '0;
            rsp_data_r  <= '0;
            rsp_valid_r <= 1'b0;
            rsp_last_r  <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            lat_cnt_r   <= lat_cnt_nxt_s;
            beat_cnt_r  <= beat_cnt_nxt_s;
            base_hi_r   <= base_hi_nxt_s;
            off_r       <= off_nxt_s;
            rsp_data_r  <= data_nxt_s;
            rsp_valid_r <= valid_nxt_s;
            rsp_last_r  <= last_nxt_s;
            req_ready_r <= ready_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_word_idx = off_r;
    assign rsp_last     = rsp_last_r;
    assign busy         = busy_r;

endmodule
